// File: rtl/aurora_tx_top_if.sv
// rtl/aurora_tx_top_if.sv - aurora lane constants, AXI-Stream beat interface and simplex status interface
package aurora_pkg;
  localparam int MAX_LINKS         = 4;
  localparam int MAX_LINKS_SIZE    = 2;
  localparam int ENCODED_DATA_SIZE = 66;
endpackage

interface aurora_axis_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

interface aurora_simplex_if;
  logic [aurora_pkg::MAX_LINKS-1:0] lane_up;
  logic                             channel_up;
  logic                             sep_sent;
  modport master (output lane_up, channel_up, sep_sent);
  modport slave  (input lane_up, channel_up, sep_sent);
endinterface

// File: rtl/aurora_tx_top.sv
// rtl/aurora_tx_top.sv - simplex 64B/66B transmit framer with one-lane or striped routing
// Optional payload scrambler (x^58+x^39+1) per lane enabled by AURORA_SCRAMBLE_EN.
module aurora_tx_top
  import aurora_pkg::*;
#(
  parameter int INIT_CYCLES = 16
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           single_lane,
  input  logic [MAX_LINKS_SIZE-1:0]                      lane_select,
  aurora_axis_if.slave                                   axi_stream,
  aurora_simplex_if.master                               simplex_operations,
  output logic [MAX_LINKS-1:0][ENCODED_DATA_SIZE-1:0]    data_out
);

  localparam logic [63:0] IDLE_PAYLOAD = 64'h78;
  localparam logic [63:0] SEP_PAYLOAD  = 64'h1E;
  localparam logic [1:0]  HDR_DATA     = 2'b01;
  localparam logic [1:0]  HDR_CTRL     = 2'b10;
  localparam int          CNT_W        = $clog2(INIT_CYCLES + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                           state;
  logic [CNT_W-1:0]                 init_cnt;
  logic [MAX_LINKS_SIZE-1:0]        ptr;
  logic [MAX_LINKS_SIZE-1:0]        eff_ptr;
  logic [MAX_LINKS_SIZE-1:0]        ptr_next;
  logic [MAX_LINKS_SIZE-1:0]        tgt;
  logic                             single_q;
  logic                             sep_pending;
  logic                             accept;
  logic [MAX_LINKS-1:0][1:0]        hdr;
  logic [MAX_LINKS-1:0][63:0]       pay;
  logic [MAX_LINKS-1:0][63:0]       pay_out;

  // A mode toggle restarts striping at lane 0 for the block built this cycle.
  always_comb begin
    accept   = (state == ST_RUN) && axi_stream.tready && axi_stream.tvalid;
    eff_ptr  = (single_lane != single_q) ? '0 : ptr;
    tgt      = single_lane ? lane_select : eff_ptr;
    ptr_next = eff_ptr;
    if (!single_lane && (accept || sep_pending))
      ptr_next = (eff_ptr == MAX_LINKS_SIZE'(MAX_LINKS - 1)) ? '0 : eff_ptr + 1'b1;
    for (int l = 0; l < MAX_LINKS; l++) begin
      hdr[l] = HDR_CTRL;
      pay[l] = IDLE_PAYLOAD;
    end
    if (accept) begin
      hdr[tgt] = HDR_DATA;
      pay[tgt] = axi_stream.tdata;
    end else if (sep_pending) begin
      pay[tgt] = SEP_PAYLOAD;
    end
  end

`ifdef AURORA_SCRAMBLE_EN
  logic [MAX_LINKS-1:0][57:0] scr_state;
  logic [MAX_LINKS-1:0][57:0] scr_next;

  // Bit 0 first; each scrambled bit feeds back into the shift register.
  function automatic logic [121:0] scramble(input logic [63:0] din, input logic [57:0] sin);
    logic [57:0] s;
    logic [63:0] o;
    s = sin;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      o[i] = din[i] ^ s[38] ^ s[57];
      s    = {s[56:0], o[i]};
    end
    return {s, o};
  endfunction

  always_comb begin
    scr_next = scr_state;
    pay_out  = pay;
    for (int l = 0; l < MAX_LINKS; l++)
      {scr_next[l], pay_out[l]} = scramble(pay[l], scr_state[l]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scr_state <= '1;
    else        scr_state <= scr_next;
  end
`else
  assign pay_out = pay;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                         <= ST_INIT;
      init_cnt                      <= '0;
      ptr                           <= '0;
      single_q                      <= 1'b0;
      sep_pending                   <= 1'b0;
      axi_stream.tready             <= 1'b0;
      simplex_operations.lane_up    <= '0;
      simplex_operations.channel_up <= 1'b0;
      simplex_operations.sep_sent   <= 1'b0;
      data_out                      <= '0;
    end else begin
      for (int l = 0; l < MAX_LINKS; l++)
        data_out[l] <= {hdr[l], pay_out[l]};
      single_q <= single_lane;
      ptr      <= ptr_next;
      case (state)
        ST_INIT: begin
          if (init_cnt == CNT_W'(INIT_CYCLES)) begin
            state                         <= ST_RUN;
            axi_stream.tready             <= 1'b1;
            simplex_operations.lane_up    <= '1;
            simplex_operations.channel_up <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // The cycle after a tlast beat is reserved for the separator.
          axi_stream.tready           <= !(accept && axi_stream.tlast);
          sep_pending                 <= accept && axi_stream.tlast;
          simplex_operations.sep_sent <= sep_pending;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_tx_top.sv
// tb/tb_aurora_tx_top.sv - scoreboard bench for aurora_tx_top framing, routing, separators and reset
module tb_aurora_tx_top;
  import aurora_pkg::*;

  localparam logic [65:0] IDLE_BLK = 66'h2_0000_0000_0000_0078;
  localparam logic [65:0] SEP_BLK  = 66'h2_0000_0000_0000_001E;

  typedef struct {
    int          lane;
    logic [65:0] blk;
    logic        sep;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic single_lane;
  logic [MAX_LINKS_SIZE-1:0] lane_select;
  logic [MAX_LINKS-1:0][ENCODED_DATA_SIZE-1:0] data_out;

  aurora_axis_if    axis();
  aurora_simplex_if simp();

  aurora_tx_top #(.INIT_CYCLES(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .single_lane        (single_lane),
    .lane_select        (lane_select),
    .axi_stream         (axis),
    .simplex_operations (simp),
    .data_out           (data_out)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_lanes(input string name, input logic [65:0] exp);
    for (int l = 0; l < MAX_LINKS; l++)
      chk($sformatf("%s_lane%0d", name, l), data_out[l], exp);
  endtask

  // Every non-idle block on any lane must match the next scoreboard entry.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        bit seen_sep;
        seen_sep = 1'b0;
        for (int l = 0; l < MAX_LINKS; l++) begin
          if (data_out[l] !== IDLE_BLK) begin
            n_cmp++;
            if (data_out[l] === SEP_BLK) seen_sep = 1'b1;
            if (sb.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_block: lane %0d got %h expected idle", l, data_out[l]);
            end else begin
              exp_t e;
              e = sb.pop_front();
              if (e.lane != l || data_out[l] !== e.blk || simp.sep_sent !== e.sep) begin
                n_err++;
                $display("FAIL block: got lane %0d blk %h sep %0b expected lane %0d blk %h sep %0b",
                         l, data_out[l], simp.sep_sent, e.lane, e.blk, e.sep);
              end
            end
          end
        end
        if (simp.sep_sent === 1'b1 && !seen_sep) begin
          n_cmp++;
          n_err++;
          $display("FAIL sep_sent: got 1 with no separator block expected 0");
        end
      end
    end
  endtask

  task automatic send(input logic [63:0] d, input logic last, input int lane, input int sep_lane);
    bit ok;
    ok = 1'b0;
    axis.tdata  = d;
    axis.tlast  = last;
    axis.tvalid = 1'b1;
    sb.push_back('{lane, {2'b01, d}, 1'b0});
    if (last) sb.push_back('{sep_lane, SEP_BLK, 1'b1});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axis.tready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got tready 0 for 20 cycles expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      check_lanes($sformatf("init%0d", k), IDLE_BLK);
      chk($sformatf("init%0d_tready", k), 66'(axis.tready), 66'd0);
      chk($sformatf("init%0d_lane_up", k), 66'(simp.lane_up), 66'd0);
    end
    @(posedge clk);
    #1;
    chk("run_lane_up", 66'(simp.lane_up), 66'hF);
    chk("run_channel_up", 66'(simp.channel_up), 66'd1);
    chk("run_tready", 66'(axis.tready), 66'd1);
  endtask

  task automatic check_reset(input string name);
    check_lanes(name, 66'd0);
    chk({name, "_tready"}, 66'(axis.tready), 66'd0);
    chk({name, "_lane_up"}, 66'(simp.lane_up), 66'd0);
    chk({name, "_channel_up"}, 66'(simp.channel_up), 66'd0);
    chk({name, "_sep_sent"}, 66'(simp.sep_sent), 66'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    single_lane = 1'b1;
    lane_select = 2'd1;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    axis.tdata  = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    do_init();
    mon_en = 1'b1;

    // One-lane mode on lane 1, single-beat frame.
    send(64'h0123_4567_89AB_CDEF, 1'b1, 1, 1);
    chk("sep_cycle_tready", 66'(axis.tready), 66'd0);
    idle(3);

    // Striped mode: beats land 0,1,2,3,0 and the separator on lane 1.
    single_lane = 1'b0;
    send(64'd1, 1'b0, 0, 0);
    send(64'd2, 1'b0, 1, 0);
    send(64'd3, 1'b0, 2, 0);
    send(64'd4, 1'b0, 3, 0);
    send(64'd5, 1'b1, 0, 1);
    idle(3);

    // Back-to-back single-beat frames with tvalid held: A, SEP, B, SEP.
    send(64'hAAAA_AAAA_0000_0001, 1'b1, 2, 3);
    send(64'hBBBB_BBBB_0000_0002, 1'b1, 0, 1);
    idle(3);

    // One-lane mode on lane 3 with a two-beat frame.
    single_lane = 1'b1;
    lane_select = 2'd3;
    send(64'hDEAD_BEEF_0000_0010, 1'b0, 3, 3);
    send(64'hDEAD_BEEF_0000_0011, 1'b1, 3, 3);
    idle(3);

    // Returning to striped mode restarts at lane 0.
    single_lane = 1'b0;
    send(64'hCAFE_F00D_1234_5678, 1'b1, 0, 1);
    idle(3);
    chk("sb_drained_1", 66'(sb.size()), 66'd0);

    // Reset in the middle of a frame.
    send(64'h5555_0000_0000_0001, 1'b0, 2, 2);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("sb_drained_2", 66'(sb.size()), 66'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    @(posedge clk);
    #1;
    do_init();
    mon_en = 1'b1;
    send(64'h7777_6666_5555_4444, 1'b1, 0, 1);
    idle(3);
    chk("sb_drained_3", 66'(sb.size()), 66'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
